// File: rtl/muldiv_rv64m.sv
// Iterative RV64M multiply/divide unit (MUL*, DIV*, REM* and W variants).
// Radix-2 shift-add multiply and restoring divide on operand magnitudes.
module muldiv_rv64m #(
    parameter int XLEN = 64
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic            is_word,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int HW = XLEN / 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [6:0]        cnt_q, cnt_d;
    logic [2:0]        fn_q, fn_d;
    logic              word_q, word_d;
    logic              neg_q, neg_d;
    logic              rneg_q, rneg_d;
    logic              dz_q, dz_d;
    logic [XLEN-1:0]   dvd_q, dvd_d;
    logic [2*XLEN-1:0] opa_q, opa_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic            a_sgn, b_sgn, sa, sb;
    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag;

    logic [XLEN:0]   rem_sh, rem_sub;
    logic            rem_ge;

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, sel_fix, res_fix;

    // Operand extension, sign detection and magnitudes for the start cycle
    always_comb begin
        a_sgn = 1'b0;
        b_sgn = 1'b0;
        unique case (funct3)
            3'b001: begin
                a_sgn = 1'b1;
                b_sgn = 1'b1;
            end
            3'b010: a_sgn = 1'b1;
            3'b100, 3'b110: begin
                a_sgn = 1'b1;
                b_sgn = 1'b1;
            end
            default: ;
        endcase
        a_ext = rs1;
        b_ext = rs2;
        if (is_word) begin
            // MULW only keeps the low word, so signedness is irrelevant
            if (!funct3[2]) begin
                a_sgn = 1'b0;
                b_sgn = 1'b0;
            end
            a_ext = a_sgn ? {{HW{rs1[HW-1]}}, rs1[HW-1:0]}
                          : {{HW{1'b0}}, rs1[HW-1:0]};
            b_ext = b_sgn ? {{HW{rs2[HW-1]}}, rs2[HW-1:0]}
                          : {{HW{1'b0}}, rs2[HW-1:0]};
        end
        sa    = a_sgn & a_ext[XLEN-1];
        sb    = b_sgn & b_ext[XLEN-1];
        a_mag = sa ? -a_ext : a_ext;
        b_mag = sb ? -b_ext : b_ext;
    end

    // One restoring-division step: shift in next dividend bit, try subtract
    always_comb begin
        rem_sh  = {acc_q[XLEN-1:0], opb_q[XLEN-1]};
        rem_sub = rem_sh - {1'b0, opa_q[XLEN-1:0]};
        rem_ge  = rem_sh >= {1'b0, opa_q[XLEN-1:0]};
    end

    // Sign correction, special cases and result selection
    always_comb begin
        prod_fix = neg_q ? -acc_q : acc_q;
        quo_fix  = neg_q ? -opb_q : opb_q;
        rem_fix  = rneg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        if (dz_q) begin
            quo_fix = '1;
            rem_fix = dvd_q;
        end
        if (fn_q[2]) begin
            sel_fix = fn_q[1] ? rem_fix : quo_fix;
        end else if (word_q || fn_q[1:0] == 2'b00) begin
            sel_fix = prod_fix[XLEN-1:0];
        end else begin
            sel_fix = prod_fix[2*XLEN-1:XLEN];
        end
        res_fix = word_q ? {{HW{sel_fix[HW-1]}}, sel_fix[HW-1:0]} : sel_fix;
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fn_d     = fn_q;
        word_d   = word_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        dvd_d    = dvd_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        result_d = result_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CALC;
                    cnt_d   = is_word ? 7'd32 : 7'd64;
                    fn_d    = funct3;
                    word_d  = is_word;
                    neg_d   = sa ^ sb;
                    rneg_d  = sa;
                    dz_d    = (b_ext == '0);
                    dvd_d   = a_ext;
                    acc_d   = '0;
                    if (funct3[2]) begin
                        opa_d = {{XLEN{1'b0}}, b_mag};
                        opb_d = is_word ? {a_mag[HW-1:0], {HW{1'b0}}} : a_mag;
                    end else begin
                        opa_d = {{XLEN{1'b0}}, a_mag};
                        opb_d = b_mag;
                    end
                end
            end
            S_CALC: begin
                cnt_d = cnt_q - 7'd1;
                if (fn_q[2]) begin
                    acc_d = {{(XLEN-1){1'b0}}, rem_ge ? rem_sub : rem_sh};
                    opb_d = {opb_q[XLEN-2:0], rem_ge};
                end else begin
                    if (opb_q[0]) begin
                        acc_d = acc_q + opa_q;
                    end
                    opa_d = opa_q << 1;
                    opb_d = opb_q >> 1;
                end
                if (cnt_q == 7'd1) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                result_d = res_fix;
                state_d  = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            fn_q     <= '0;
            word_q   <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            dvd_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            fn_q     <= fn_d;
            word_q   <= word_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
            dvd_q    <= dvd_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == S_CALC) || (state_q == S_FIX);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_rv64m.sv
// Bench for muldiv_rv64m: directed RV64M cases plus random ops
// checked against a plain-arithmetic reference model.
module tb_muldiv_rv64m;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic        is_word;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic        busy;
    logic        done;
    logic [63:0] result;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    muldiv_rv64m dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .funct3 (funct3),
        .is_word(is_word),
        .rs1    (rs1),
        .rs2    (rs2),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_model(input logic [2:0] f3,
                                              input logic w,
                                              input logic [63:0] a,
                                              input logic [63:0] b);
        logic [127:0] p;
        logic [31:0]  r32;
        logic [63:0]  r64;
        int           wa, wb;
        longint       la, lb;
        if (!f3[2]) begin
            if (w) begin
                r32 = a[31:0] * b[31:0];
                return {{32{r32[31]}}, r32};
            end
            case (f3)
                3'd0: p = {64'd0, a} * {64'd0, b};
                3'd1: p = {{64{a[63]}}, a} * {{64{b[63]}}, b};
                3'd2: p = {{64{a[63]}}, a} * {64'd0, b};
                default: p = {64'd0, a} * {64'd0, b};
            endcase
            return (f3 == 3'd0) ? p[63:0] : p[127:64];
        end
        if (w) begin
            wa = a[31:0];
            wb = b[31:0];
            if (b[31:0] == 32'd0) begin
                r32 = f3[1] ? a[31:0] : 32'hFFFF_FFFF;
            end else if (!f3[0]) begin
                if (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                    r32 = f3[1] ? 32'd0 : 32'h8000_0000;
                else
                    r32 = f3[1] ? wa % wb : wa / wb;
            end else begin
                r32 = f3[1] ? a[31:0] % b[31:0] : a[31:0] / b[31:0];
            end
            return {{32{r32[31]}}, r32};
        end
        la = a;
        lb = b;
        if (b == 64'd0) begin
            r64 = f3[1] ? a : 64'hFFFF_FFFF_FFFF_FFFF;
        end else if (!f3[0]) begin
            if (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF)
                r64 = f3[1] ? 64'd0 : a;
            else
                r64 = f3[1] ? la % lb : la / lb;
        end else begin
            r64 = f3[1] ? a % b : a / b;
        end
        return r64;
    endfunction

    function automatic logic [63:0] rnd();
        logic [63:0] v;
        case ($urandom_range(0, 6))
            0: v = 64'd0;
            1: v = 64'hFFFF_FFFF_FFFF_FFFF;
            2: v = 64'h8000_0000_0000_0000;
            3: v = {$urandom, 32'h8000_0000};
            4: v = 64'($urandom_range(0, 9));
            5: v = -64'($urandom_range(1, 9));
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    // Runs one op; poke>0 re-asserts start with junk at that busy cycle
    task automatic run_op(input string tag, input logic [2:0] f3,
                          input logic w, input logic [63:0] a,
                          input logic [63:0] b, input int poke);
        logic [63:0] exp;
        int n;
        int lat;
        exp = ref_model(f3, w, a, b);
        lat = w ? 34 : 66;
        @(negedge clock);
        start   = 1'b1;
        funct3  = f3;
        is_word = w;
        rs1     = a;
        rs2     = b;
        @(posedge clock);
        #1;
        start   = 1'b0;
        rs1     = {$urandom, $urandom};
        rs2     = {$urandom, $urandom};
        funct3  = 3'($urandom_range(0, 7));
        is_word = 1'($urandom_range(0, 1));
        n = 1;
        check({tag, "/busy"}, 64'(busy), 64'd1);
        while (!done && n < 200) begin
            @(posedge clock);
            #1;
            n++;
            start = (n == poke);
        end
        start = 1'b0;
        check({tag, "/lat"}, 64'(n), 64'(lat));
        check({tag, "/res"}, result, exp);
        check({tag, "/idle"}, 64'(busy), 64'd0);
        @(posedge clock);
        #1;
        check({tag, "/pulse"}, 64'(done), 64'd0);
    endtask

    task automatic reset_mid_op();
        int n;
        int pulses;
        @(negedge clock);
        start   = 1'b1;
        funct3  = 3'b100;
        is_word = 1'b0;
        rs1     = 64'd1000;
        rs2     = 64'd3;
        @(posedge clock);
        #1;
        start = 1'b0;
        n = 1;
        while (n < 19) begin
            @(posedge clock);
            #1;
            n++;
        end
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("rstmid/busy", 64'(busy), 64'd0);
        check("rstmid/res", result, 64'd0);
        check("rstmid/done", 64'(done), 64'd0);
        pulses = 0;
        repeat (80) begin
            @(posedge clock);
            #1;
            if (done) pulses++;
        end
        check("rstmid/nodone", 64'(pulses), 64'd0);
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        funct3  = 3'd0;
        is_word = 1'b0;
        rs1     = 64'd0;
        rs2     = 64'd0;
        repeat (2) @(posedge clock);
        #1;
        check("rst/busy", 64'(busy), 64'd0);
        check("rst/done", 64'(done), 64'd0);
        check("rst/res", result, 64'd0);
        @(negedge clock);
        reset = 1'b0;

        run_op("mul", 3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, -1);
        check("mul/const", result, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op("mulhu", 3'd3, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, -1);
        check("mulhu/const", result, 64'd6);
        run_op("mulh_m1", 3'd1, 1'b0, '1, '1, -1);
        run_op("mulhsu", 3'd2, 1'b0, '1, 64'd2, -1);
        check("mulhsu/const", result, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("mulh_min", 3'd1, 1'b0, 64'h8000_0000_0000_0000,
               64'h8000_0000_0000_0000, -1);
        check("mulh_min/const", result, 64'h4000_0000_0000_0000);
        run_op("div", 3'd4, 1'b0, -64'd7, 64'd2, -1);
        check("div/const", result, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("rem", 3'd6, 1'b0, -64'd7, 64'd2, -1);
        check("rem/const", result, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("divu", 3'd5, 1'b0, 64'd100, 64'd7, -1);
        run_op("remu", 3'd7, 1'b0, 64'd100, 64'd7, -1);
        run_op("div0", 3'd4, 1'b0, 64'd5, 64'd0, -1);
        run_op("rem0", 3'd6, 1'b0, 64'd5, 64'd0, -1);
        check("rem0/const", result, 64'd5);
        run_op("divovf", 3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, -1);
        run_op("removf", 3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, -1);
        run_op("divwovf", 3'd4, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, -1);
        check("divwovf/const", result, 64'hFFFF_FFFF_8000_0000);
        run_op("remw0", 3'd6, 1'b1, 64'h1234_5678_8765_4321, 64'h7_0000_0000, -1);
        run_op("divuw0", 3'd5, 1'b1, 64'h55, 64'hFFFF_FFFF_0000_0000, -1);
        run_op("mulw", 3'd0, 1'b1, 64'h0001_0000, 64'h0000_8000, -1);
        check("mulw/const", result, 64'hFFFF_FFFF_8000_0000);
        run_op("divuw", 3'd5, 1'b1, 64'hFFFF_FFFE, 64'd1, -1);
        check("divuw/const", result, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op("remuw", 3'd7, 1'b1, 64'hFFFF_FFFF, 64'd10, -1);
        run_op("poke", 3'd4, 1'b0, 64'd1000, 64'd7, 10);
        check("poke/const", result, 64'd142);
        reset_mid_op();
        run_op("b2b_mul", 3'd0, 1'b0, 64'd123456789, 64'd987654321, -1);
        run_op("b2b_div", 3'd4, 1'b0, -64'd1000001, 64'd13, -1);

        for (int i = 0; i < 60; i++) begin
            run_op("rand", 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   rnd(), rnd(), -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
